// File: rtl/l2_line_responder_if.sv
// l2_line_responder_if
//   Bundles the two request/response channels of the L2 line responder.
//   Upstream (L2 cache side):
//     l2cache_address  16-bit line address, bits [3:0] ignored
//     l2cache_wdata    128-bit write line
//     l2cache_rdata    128-bit read line, valid while l2_resp is high
//     l2_read/l2_write request strobes, held until l2_resp
//     l2_resp          one-cycle completion pulse
//   Downstream (physical memory side):
//     pmem_address/pmem_wdata/pmem_read/pmem_write  held until pmem_resp
//     pmem_rdata/pmem_resp                          memory answer
//   Modports: slave = the responder, master = the agent that drives the
//   L2 requests and plays physical memory.
interface l2_line_responder_if;
  logic [15:0]  l2cache_address;
  logic [127:0] l2cache_wdata;
  logic [127:0] l2cache_rdata;
  logic         l2_read;
  logic         l2_write;
  logic         l2_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic         pmem_resp;

  modport slave (
    input  l2cache_address, l2cache_wdata, l2_read, l2_write,
    input  pmem_rdata, pmem_resp,
    output l2cache_rdata, l2_resp,
    output pmem_address, pmem_wdata, pmem_read, pmem_write
  );

  modport master (
    output l2cache_address, l2cache_wdata, l2_read, l2_write,
    output pmem_rdata, pmem_resp,
    input  l2cache_rdata, l2_resp,
    input  pmem_address, pmem_wdata, pmem_read, pmem_write
  );
endinterface

// File: rtl/l2_line_responder.sv
// l2_line_responder
//   Services L2 line reads/writes through a one-entry write buffer that is
//   drained to physical memory whenever the upstream side is quiet.
//   Ports:
//     clk    sole clock, rising edge
//     rst_n  asynchronous active-low reset; discards any undrained line
//     bus    l2_line_responder_if.slave (L2 request side + pmem side)
//   Configuration:
//     L2_WB_FORWARD_EN  when defined, a read that hits the buffered line is
//                       answered straight from the buffer; otherwise the
//                       buffer is drained first and the line fetched again.
module l2_line_responder (
  input  logic                      clk,
  input  logic                      rst_n,
  l2_line_responder_if.slave        bus
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE_ACK,
    READ_MEM,
    READ_ACK,
    DRAIN
  } state_t;

  state_t       r_state;
  state_t       w_next;

  logic         r_valid;
  logic [11:0]  r_tag;
  logic [127:0] r_data;
  logic [127:0] r_rdata;

  logic [11:0]  w_req_tag;
  logic         w_tag_match;
  logic         w_load_buf;
  logic         w_fwd;

  assign w_req_tag   = bus.l2cache_address[15:4];
  assign w_tag_match = (r_tag == w_req_tag);

  // Writes take precedence over reads; any pending request takes precedence
  // over an opportunistic drain. Once DRAIN or READ_MEM is entered it runs
  // to pmem_resp, so requests arriving meanwhile wait in IDLE.
  always_comb begin
    w_next     = r_state;
    w_load_buf = 1'b0;
    w_fwd      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.l2_write) begin
          if (!r_valid || w_tag_match) begin
            w_load_buf = 1'b1;
            w_next     = WRITE_ACK;
          end else begin
            w_next = DRAIN;
          end
        end else if (bus.l2_read) begin
          if (r_valid && w_tag_match) begin
`ifdef L2_WB_FORWARD_EN
            w_fwd  = 1'b1;
            w_next = READ_ACK;
`else
            w_next = DRAIN;
`endif
          end else begin
            w_next = READ_MEM;
          end
        end else if (r_valid) begin
          w_next = DRAIN;
        end
      end
      WRITE_ACK: w_next = IDLE;
      READ_ACK:  w_next = IDLE;
      READ_MEM:  if (bus.pmem_resp) w_next = READ_ACK;
      DRAIN:     if (bus.pmem_resp) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // State register plus buffer/read-data updates. pmem_resp is only acted
  // on in READ_MEM and DRAIN, so a stray response elsewhere is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_buf) begin
        r_valid <= 1'b1;
        r_tag   <= w_req_tag;
        r_data  <= bus.l2cache_wdata;
      end
      if (r_state == DRAIN && bus.pmem_resp) begin
        r_valid <= 1'b0;
      end
      if (r_state == READ_MEM && bus.pmem_resp) begin
        r_rdata <= bus.pmem_rdata;
      end
      if (w_fwd) begin
        r_rdata <= r_data;
      end
    end
  end

  // Outputs decode directly from state so that an asynchronous reset drops
  // every strobe and bus at once. The read address is taken live from the
  // request, which the requester holds stable until l2_resp.
  always_comb begin
    bus.l2_resp       = (r_state == WRITE_ACK) || (r_state == READ_ACK);
    bus.l2cache_rdata = r_rdata;
    bus.pmem_read     = (r_state == READ_MEM);
    bus.pmem_write    = (r_state == DRAIN);
    bus.pmem_address  = 16'h0000;
    bus.pmem_wdata    = '0;
    if (r_state == READ_MEM) begin
      bus.pmem_address = {w_req_tag, 4'h0};
    end else if (r_state == DRAIN) begin
      bus.pmem_address = {r_tag, 4'h0};
      bus.pmem_wdata   = r_data;
    end
  end

endmodule

// File: tb/tb_l2_line_responder.sv
module tb_l2_line_responder;

  logic clk;
  logic rst_n;

  l2_line_responder_if bus ();

  l2_line_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun  = 0;
  int failCount = 0;

  // Physical memory model state.
  int           pmemLatency = 3;
  logic [127:0] pmemReadData = '0;
  int           writeCount = 0;
  int           readCount = 0;
  int           pmemReadCycles = 0;
  int           pmemWriteCycles = 0;
  logic [15:0]  lastWriteAddr = '0;
  logic [127:0] lastWriteData = '0;
  logic [15:0]  lastReadAddr = '0;
  logic         bothSeen = 1'b0;

  // Memory model: answers a held pmem request after pmemLatency cycles
  // with a one-cycle pmem_resp, and logs traffic. Runs 2 time units after
  // each rising edge so it never races the negedge sampling below.
  initial begin
    int busy;
    busy = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.pmem_read && bus.pmem_write) bothSeen = 1'b1;
      if (bus.pmem_read) pmemReadCycles++;
      if (bus.pmem_write) pmemWriteCycles++;
      if (!rst_n) begin
        bus.pmem_resp = 1'b0;
        busy = 0;
      end else if (bus.pmem_resp) begin
        bus.pmem_resp = 1'b0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        busy++;
        if (busy >= pmemLatency) begin
          busy = 0;
          bus.pmem_resp = 1'b1;
          if (bus.pmem_write) begin
            writeCount++;
            lastWriteAddr = bus.pmem_address;
            lastWriteData = bus.pmem_wdata;
          end else begin
            readCount++;
            lastReadAddr   = bus.pmem_address;
            bus.pmem_rdata = pmemReadData;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [15:0] addr,
                               input logic [127:0] data);
    bus.l2_read         = rd;
    bus.l2_write        = wr;
    bus.l2cache_address = addr;
    bus.l2cache_wdata   = data;
  endtask

  // Returns the number of negedges from the call until l2_resp is seen,
  // or -1 if it never arrives within the budget.
  task automatic waitResp(input int maxCycles, output int cycles);
    bit got;
    got = 0;
    cycles = 0;
    while (cycles < maxCycles && !got) begin
      @(negedge clk);
      cycles++;
      if (bus.l2_resp) got = 1;
    end
    if (!got) cycles = -1;
  endtask

  // Waits for the next completed pmem write, then lets the DUT settle
  // back into IDLE.
  task automatic waitDrain(input int prevCount, input string tag);
    int n;
    n = 0;
    while (writeCount == prevCount && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 128'(writeCount != prevCount), 128'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cyc;
    int wc;
    int rc;
    int wcyc;
    int rcyc;
    bit seen;
    logic [127:0] dA5;
    logic [127:0] dDead;
    logic [127:0] d1111;
    logic [127:0] d5670;
    logic [127:0] dCafe;
    logic [127:0] dBad;
    logic [127:0] d77;
    logic [127:0] d22;

    dA5   = {16{8'hA5}};
    dDead = {8{16'hDEAD}};
    d1111 = {8{16'h1111}};
    d5670 = {8{16'h5670}};
    dCafe = {4{32'hCAFEF00D}};
    dBad  = {4{32'h0BADBEEF}};
    d77   = {16{8'h77}};
    d22   = {4{32'h22223333}};

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000, '0);
    repeat (3) @(negedge clk);
    checkOutput("rst_l2_resp", 128'(bus.l2_resp), 128'd0);
    checkOutput("rst_pmem_read", 128'(bus.pmem_read), 128'd0);
    checkOutput("rst_pmem_write", 128'(bus.pmem_write), 128'd0);
    checkOutput("rst_rdata", bus.l2cache_rdata, 128'd0);
    checkOutput("rst_pmem_addr", 128'(bus.pmem_address), 128'd0);
    checkOutput("rst_pmem_wdata", bus.pmem_wdata, 128'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write into an empty buffer, then let it drain.
    wc = writeCount;
    applyStimulus(1'b0, 1'b1, 16'h1230, dA5);
    waitResp(10, cyc);
    checkOutput("wr_empty_latency", 128'(cyc), 128'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, '0);
    waitDrain(wc, "wr_empty_drain_seen");
    checkOutput("wr_empty_drain_addr", 128'(lastWriteAddr), 128'h1230);
    checkOutput("wr_empty_drain_data", lastWriteData, dA5);

    // Read miss with a 5-cycle memory.
    pmemLatency  = 5;
    pmemReadData = dDead;
    rcyc = pmemReadCycles;
    applyStimulus(1'b1, 1'b0, 16'h4000, '0);
    waitResp(20, cyc);
    checkOutput("rd_miss_latency", 128'(cyc), 128'd6);
    checkOutput("rd_miss_data", bus.l2cache_rdata, dDead);
    checkOutput("rd_miss_pmem_cycles", 128'(pmemReadCycles - rcyc), 128'd5);
    checkOutput("rd_miss_addr", 128'(lastReadAddr), 128'h4000);
    applyStimulus(1'b0, 1'b0, 16'h0000, '0);
    pmemReadData = '0;
    repeat (3) @(negedge clk);
    checkOutput("rd_miss_data_held", bus.l2cache_rdata, dDead);
    pmemLatency = 3;

    // Write conflict: second write to another line is kept asserted right
    // after the first ack, forcing a drain before it is accepted.
    applyStimulus(1'b0, 1'b1, 16'h1230, d1111);
    waitResp(10, cyc);
    checkOutput("conf_first_latency", 128'(cyc), 128'd1);
    wc = writeCount;
    applyStimulus(1'b0, 1'b1, 16'h5670, d5670);
    waitResp(40, cyc);
    checkOutput("conf_second_seen", 128'(cyc > 0), 128'd1);
    checkOutput("conf_drain_before_resp", 128'(writeCount - wc), 128'd1);
    checkOutput("conf_drain_addr", 128'(lastWriteAddr), 128'h1230);
    checkOutput("conf_drain_data", lastWriteData, d1111);
    applyStimulus(1'b0, 1'b0, 16'h0000, '0);
    wc = writeCount;
    waitDrain(wc, "conf_new_drain_seen");
    checkOutput("conf_new_tag_addr", 128'(lastWriteAddr), 128'h5670);
    checkOutput("conf_new_tag_data", lastWriteData, d5670);

    // Read of 0x1238 right after writing line 0x1230.
    applyStimulus(1'b0, 1'b1, 16'h1230, dCafe);
    waitResp(10, cyc);
    wc = writeCount;
    rc = readCount;
    pmemReadData = dBad;
    applyStimulus(1'b1, 1'b0, 16'h1238, '0);
    waitResp(40, cyc);
`ifdef L2_WB_FORWARD_EN
    checkOutput("hit_fwd_latency", 128'(cyc), 128'd2);
    checkOutput("hit_fwd_data", bus.l2cache_rdata, dCafe);
    checkOutput("hit_fwd_no_read", 128'(readCount - rc), 128'd0);
    checkOutput("hit_fwd_no_write", 128'(writeCount - wc), 128'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, '0);
    waitDrain(wc, "hit_fwd_later_drain");
    checkOutput("hit_fwd_drain_addr", 128'(lastWriteAddr), 128'h1230);
`else
    checkOutput("hit_seen", 128'(cyc > 0), 128'd1);
    checkOutput("hit_drain_count", 128'(writeCount - wc), 128'd1);
    checkOutput("hit_drain_addr", 128'(lastWriteAddr), 128'h1230);
    checkOutput("hit_drain_data", lastWriteData, dCafe);
    checkOutput("hit_read_count", 128'(readCount - rc), 128'd1);
    checkOutput("hit_read_addr", 128'(lastReadAddr), 128'h1230);
    checkOutput("hit_read_data", bus.l2cache_rdata, dBad);
    applyStimulus(1'b0, 1'b0, 16'h0000, '0);
    repeat (2) @(negedge clk);
`endif

    // Reset while a drain is in flight.
    pmemLatency = 20;
    applyStimulus(1'b0, 1'b1, 16'h7770, d77);
    waitResp(10, cyc);
    checkOutput("rdrain_wr_latency", 128'(cyc), 128'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, '0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.pmem_write) seen = 1;
    end
    checkOutput("rdrain_started", 128'(seen), 128'd1);
    wc = writeCount;
    rst_n = 1'b0;
    #1;
    checkOutput("rdrain_pmem_write_drop", 128'(bus.pmem_write), 128'd0);
    checkOutput("rdrain_pmem_addr_zero", 128'(bus.pmem_address), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pmemLatency = 3;
    wcyc = pmemWriteCycles;
    repeat (30) @(negedge clk);
    checkOutput("rdrain_no_drain_after", 128'(pmemWriteCycles - wcyc), 128'd0);
    checkOutput("rdrain_no_write_done", 128'(writeCount - wc), 128'd0);

    // Read and write together are a write.
    rc = readCount;
    wc = writeCount;
    applyStimulus(1'b1, 1'b1, 16'h2220, d22);
    waitResp(10, cyc);
    checkOutput("both_latency", 128'(cyc), 128'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, '0);
    waitDrain(wc, "both_drain_seen");
    checkOutput("both_drain_addr", 128'(lastWriteAddr), 128'h2220);
    checkOutput("both_drain_data", lastWriteData, d22);
    checkOutput("both_no_read", 128'(readCount - rc), 128'd0);

    checkOutput("never_read_and_write", 128'(bothSeen), 128'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/l2_line_responder.md
L2_LINE_RESPONDER -- requirements
Module: l2_line_responder

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port l2cache_address, input, 16: request line address; bits [3:0] ignored.
REQ-004 SHALL have port l2cache_wdata, input, 128: write line data.
REQ-005 SHALL have port l2cache_rdata, output, 128: read line data, valid while l2_resp=1.
REQ-006 SHALL have ports l2_read and l2_write, input, 1 each: requests, held with address/wdata stable until l2_resp.
REQ-007 SHALL have port l2_resp, output, 1: single-cycle completion pulse.
REQ-008 SHALL have ports pmem_address (output, 16), pmem_wdata (output, 128), pmem_rdata (input, 128).
REQ-009 SHALL have ports pmem_read and pmem_write (output, 1) and pmem_resp (input, 1); pmem requests are held until pmem_resp.

Function
REQ-010 SHALL hold a one-entry write buffer: valid bit, 12-bit line tag (address[15:4]), 128-bit data.
REQ-011 SHALL implement FSM states IDLE, WRITE_ACK, READ_MEM, READ_ACK, DRAIN; l2_resp=1 only in WRITE_ACK and READ_ACK, each exactly one cycle, then IDLE.
REQ-012 SHALL, in IDLE with l2_write and (buffer empty or tag match), load the buffer (valid=1) and enter WRITE_ACK; l2_resp rises the cycle after the request is first seen.
REQ-013 SHALL, in IDLE with l2_write and buffer valid with tag mismatch, enter DRAIN, then return to IDLE and service the write.
REQ-014 SHALL, in IDLE with l2_read and tag mismatch or buffer empty, enter READ_MEM: pmem_read=1, pmem_address={tag,4'h0}; on pmem_resp, capture pmem_rdata into l2cache_rdata and enter READ_ACK.
REQ-015 SHALL, in IDLE with l2_read, buffer valid and tag match, behave per REQ-027/REQ-028.
REQ-016 SHALL, in IDLE with no request and buffer valid, enter DRAIN: pmem_write=1, pmem_address={buffer tag,4'h0}, pmem_wdata=buffer data until pmem_resp; on pmem_resp clear valid and return to IDLE.
REQ-017 SHALL give pending l2 requests priority over starting a drain; a drain already started completes before any request is serviced.
REQ-018 SHALL treat l2_read and l2_write asserted together as a write (l2_write wins).
REQ-019 SHALL never assert pmem_read and pmem_write in the same cycle.
REQ-020 SHALL treat a request still asserted in the cycle after l2_resp as a new request.
REQ-021 SHALL hold l2cache_rdata constant except when loaded in READ_MEM or on a forward.

Reset
REQ-022 SHALL, on rst_n=0, immediately enter IDLE regardless of current state, including mid-DRAIN or mid-READ_MEM.
REQ-023 SHALL reset l2_resp, pmem_read, pmem_write to 0 and l2cache_rdata, pmem_address, pmem_wdata to 0.
REQ-024 SHALL clear the buffer valid bit on reset; buffered data not yet drained is discarded.
REQ-025 SHALL ignore pmem_resp arriving while in IDLE or WRITE_ACK.

Configuration
REQ-026 SHALL use macro L2_WB_FORWARD_EN to compile read forwarding in or out.
REQ-027 SHALL, with L2_WB_FORWARD_EN defined, serve a read that hits the buffer from buffer data via READ_ACK, with no pmem access (l2_resp the cycle after the request).
REQ-028 SHALL, without L2_WB_FORWARD_EN, on a read with buffer valid and tag match, drain the buffer first (DRAIN), then fetch from pmem (READ_MEM).

Verification
REQ-029 SHALL cover a write to an empty buffer: addr 0x1230, data all 0xA5 -> l2_resp at cycle+1; DRAIN writes 0xA5 line to pmem 0x1230 when idle.
REQ-030 SHALL cover a read miss: read 0x4000 with pmem_resp after 5 cycles returning 0xDEAD... -> pmem_read held 5 cycles; l2_resp with that data one cycle after pmem_resp.
REQ-031 SHALL cover a write conflict: buffer holds 0x1230, then write 0x5670 -> pmem_write to 0x1230 completes before l2_resp; buffer tag becomes 0x567.
REQ-032 SHALL cover a read hit on 0x1238 after writing 0x1230: with L2_WB_FORWARD_EN -> no pmem traffic, data returned; without it -> drain then pmem_read of 0x1230.
REQ-033 SHALL cover reset mid-DRAIN: rst_n low during pmem_write -> pmem_write=0 immediately, valid=0, no drain after release.
REQ-034 SHALL cover simultaneous l2_read and l2_write -> serviced as a write; pmem_read never asserted.
